// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO reader/writer pair: default widths,
// the burst FSM encoding and a saturating counter helper.
package fifo_pkg;

  localparam int unsigned FIFO_DATA_W       = 8;
  localparam int unsigned FIFO_DELAY_CYCLES = 10;
  localparam int unsigned BURST_LEN_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } fifo_state_e;

  // Increment that sticks at all-ones instead of wrapping
  function automatic logic [BURST_LEN_W-1:0] sat_inc(input logic [BURST_LEN_W-1:0] v);
    return (v == '1) ? v : v + BURST_LEN_W'(1);
  endfunction

endpackage

// File: rtl/fifo_seq_check.sv
// Sequence checker for captured FIFO words: expects 0,1,2,... modulo
// 2^DATA_W, raises a sticky error on any gap, and counts captured words.
// After a mismatch the expectation follows the received word, so a single
// corrupted word does not cascade into a stream of follow-on errors.
module fifo_seq_check import fifo_pkg::*; #(
  parameter int unsigned DATA_W = FIFO_DATA_W
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   rd_valid,
  input  logic [DATA_W-1:0]      rd_data,
  input  logic                   clear,
  output logic                   err_flag,
  output logic [BURST_LEN_W-1:0] count_next
);

  logic [DATA_W-1:0]      expected_q, expected_d;
  logic                   err_q, err_d;
  logic [BURST_LEN_W-1:0] word_cnt_q, word_cnt_d;
  logic [BURST_LEN_W-1:0] word_cnt_inc;

  // Compare each captured word, track the next expected value and count words
  always_comb begin
    expected_d   = expected_q;
    err_d        = err_q;
    word_cnt_inc = word_cnt_q;
    if (rd_valid) begin
      if (rd_data != expected_q) begin
        err_d = 1'b1;
      end
      expected_d   = rd_data + DATA_W'(1);
      word_cnt_inc = sat_inc(word_cnt_q);
    end
    word_cnt_d = word_cnt_inc;
    if (clear) begin
      expected_d = '0;
      word_cnt_d = '0;
    end
  end

  // Checker state; the error flag is only ever cleared by reset
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      expected_q <= '0;
      err_q      <= 1'b0;
      word_cnt_q <= '0;
    end else begin
      expected_q <= expected_d;
      err_q      <= err_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  // The count including this cycle's word, so a burst length can be taken
  // in the same cycle as the last word without losing it to the clear
  assign count_next = word_cnt_inc;
  assign err_flag   = err_q;

endmodule

// File: rtl/fifo_read.sv
// Burst reader: a rising almost_full starts a burst after a settle delay,
// words are read until almost_empty, and every word is sequence-checked.
module fifo_read import fifo_pkg::*; #(
  parameter int unsigned DATA_W       = FIFO_DATA_W,
  parameter int unsigned DELAY_CYCLES = FIFO_DELAY_CYCLES
) (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  input  logic                   almost_full,
  input  logic                   almost_empty,
  input  logic [DATA_W-1:0]      fifo_rdata,
  output logic                   fifo_rd_en,
  output logic                   rd_valid,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   burst_done,
  output logic                   err_flag,
  output logic [BURST_LEN_W-1:0] burst_len
);

  localparam int unsigned CNT_W = (DELAY_CYCLES < 1) ? 1 : $clog2(DELAY_CYCLES + 1);

  fifo_state_e            state_q, state_d;
  logic [CNT_W-1:0]       delay_cnt_q, delay_cnt_d;
  logic                   af_t0_q, af_t0_d;
  logic                   af_t1_q, af_t1_d;
  logic                   rd_en_q, rd_en_d;
  logic                   rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]      rd_hold_q, rd_hold_d;
  logic                   burst_done_q, burst_done_d;
  logic [BURST_LEN_W-1:0] burst_len_q, burst_len_d;
  logic                   trigger;
  logic                   chk_clear;
  logic [BURST_LEN_W-1:0] count_next;

  // One-cycle trigger on a rising almost_full, seen through two sync flops
  assign trigger = af_t0_q & ~af_t1_q;

  // Input synchroniser, read-valid pipeline and captured-word holding register
  always_comb begin
    af_t0_d    = almost_full;
    af_t1_d    = af_t0_q;
    rd_valid_d = rd_en_q;
    rd_hold_d  = rd_valid_q ? fifo_rdata : rd_hold_q;
  end

  // Burst FSM: next state, read enable, and end-of-burst bookkeeping
  always_comb begin
    state_d      = state_q;
    delay_cnt_d  = delay_cnt_q;
    rd_en_d      = 1'b0;
    burst_done_d = 1'b0;
    burst_len_d  = burst_len_q;
    chk_clear    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (trigger) begin
          state_d     = ST_DELAY;
          delay_cnt_d = '0;
        end
      end
      ST_DELAY: begin
        if (delay_cnt_q == CNT_W'(DELAY_CYCLES)) begin
          state_d     = ST_READ;
          rd_en_d     = 1'b1;
          delay_cnt_d = '0;
        end else begin
          delay_cnt_d = delay_cnt_q + CNT_W'(1);
        end
      end
      ST_READ: begin
        if (almost_empty) begin
          state_d = ST_DRAIN;
        end else begin
          rd_en_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        state_d      = ST_IDLE;
        burst_done_d = 1'b1;
        burst_len_d  = count_next;
        chk_clear    = 1'b1;
      end
      default: begin
        state_d     = ST_IDLE;
        delay_cnt_d = '0;
      end
    endcase
  end

  // All registered state; reset drops the read enable immediately
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      delay_cnt_q  <= '0;
      af_t0_q      <= 1'b0;
      af_t1_q      <= 1'b0;
      rd_en_q      <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_hold_q    <= '0;
      burst_done_q <= 1'b0;
      burst_len_q  <= '0;
    end else begin
      state_q      <= state_d;
      delay_cnt_q  <= delay_cnt_d;
      af_t0_q      <= af_t0_d;
      af_t1_q      <= af_t1_d;
      rd_en_q      <= rd_en_d;
      rd_valid_q   <= rd_valid_d;
      rd_hold_q    <= rd_hold_d;
      burst_done_q <= burst_done_d;
      burst_len_q  <= burst_len_d;
    end
  end

  // The FIFO presents a word in the cycle after rd_en is sampled, which is
  // exactly the rd_valid cycle, so rd_data passes it through then and holds
  // the last captured word otherwise
  assign rd_data    = rd_valid_q ? fifo_rdata : rd_hold_q;
  assign rd_valid   = rd_valid_q;
  assign fifo_rd_en = rd_en_q;
  assign burst_done = burst_done_q;
  assign burst_len  = burst_len_q;

  fifo_seq_check #(.DATA_W(DATA_W)) u_seq_check (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .rd_valid   (rd_valid_q),
    .rd_data    (rd_data),
    .clear      (chk_clear),
    .err_flag   (err_flag),
    .count_next (count_next)
  );

endmodule

// File: tb/tb_fifo_read.sv
// Bench for fifo_read: a queue-based FIFO model feeds the DUT, a monitor
// checks every captured word and the sticky error against a stream model,
// and burst tasks check timing, lengths and the done pulse.
module tb_fifo_read;

  localparam int DW      = 8;
  localparam int DLY     = 10;
  localparam int LATENCY = 2 + DLY + 1;

  logic          sys_clk      = 1'b0;
  logic          sys_rst_n    = 1'b0;
  logic          almost_full  = 1'b0;
  logic          almost_empty = 1'b0;
  logic [DW-1:0] fifo_rdata   = '0;
  logic          fifo_rd_en;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          burst_done;
  logic          err_flag;
  logic [15:0]   burst_len;

  int vecCount  = 0;
  int missCount = 0;

  logic [DW-1:0] fifoQ[$];
  logic [DW-1:0] poppedQ[$];
  logic [DW-1:0] modelNext = '0;
  bit            modelErr  = 1'b0;
  bit            monOn     = 1'b0;

  typedef struct {
    int         words;
    int         corruptIdx;
    logic [7:0] corruptVal;
    bit         aeEarly;
    bit         retrig;
    bit         expErr;
  } burst_vec_t;

  burst_vec_t vecs[6];

  fifo_read #(.DATA_W(DW), .DELAY_CYCLES(DLY)) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .fifo_rdata   (fifo_rdata),
    .fifo_rd_en   (fifo_rd_en),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .burst_done   (burst_done),
    .err_flag     (err_flag),
    .burst_len    (burst_len)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // FIFO model: a word appears one cycle after rd_en is sampled high
  initial begin : fifoModel
    bit en;
    forever begin
      @(negedge sys_clk);
      en = fifo_rd_en;
      @(posedge sys_clk);
      #1;
      if (en && sys_rst_n && fifoQ.size() > 0) begin
        fifo_rdata = fifoQ.pop_front();
        poppedQ.push_back(fifo_rdata);
      end
    end
  end

  // Stream model: every captured word must be the popped one; the error is
  // sticky and set whenever a word differs from previous word + 1
  initial begin : monitor
    logic [DW-1:0] w;
    forever begin
      @(negedge sys_clk);
      if (monOn) begin
        checkOutput("errFlag", 32'(err_flag), 32'(modelErr));
        if (rd_valid) begin
          if (poppedQ.size() == 0) begin
            checkOutput("rdValidHasWord", 32'd0, 32'd1);
          end else begin
            w = poppedQ.pop_front();
            checkOutput("rdData", 32'(rd_data), 32'(w));
            if (w != modelNext) modelErr = 1'b1;
            modelNext = w + DW'(1);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, vectors %0d", vecCount);
    $fatal(1, "[TB] timeout");
  end

  // One complete burst: load the FIFO, raise almost_full, check latency,
  // end the burst after 'words' reads, check length and the done pulse
  task automatic applyStimulus(input int words, input int corruptIdx, input logic [7:0] corruptVal,
                               input bit aeEarly, input bit retrig);
    int            c;
    int            validSeen;
    int            doneSeen;
    int            sawRdEn;
    bit            started;
    logic [DW-1:0] lastWord;
    lastWord = '0;
    for (int i = 0; i < words; i++) begin
      logic [DW-1:0] v;
      v = DW'(i);
      if (i == corruptIdx) v = corruptVal;
      fifoQ.push_back(v);
      lastWord = v;
    end
    almost_empty = 1'b0;
    @(posedge sys_clk);
    #1;
    almost_full = 1'b1;
    started = 1'b0;
    for (c = 1; c <= LATENCY + 20; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (c == 2 && !retrig) almost_full = 1'b0;
      if (retrig && c == 5) almost_full = 1'b0;
      if (retrig && c == 7) almost_full = 1'b1;
      if (aeEarly && c == LATENCY - 2) almost_empty = 1'b1;
      if (fifo_rd_en) begin
        started = 1'b1;
        break;
      end
    end
    checkOutput("rdEnLatency", started ? 32'(c) : 32'd0, 32'(LATENCY));
    if (!started) begin
      almost_full  = 1'b0;
      almost_empty = 1'b0;
      fifoQ.delete();
      return;
    end
    validSeen = 0;
    doneSeen  = 0;
    for (int i = 0; i <= words + 5; i++) begin
      if (i > 0) begin
        @(posedge sys_clk);
        @(negedge sys_clk);
      end
      if (retrig && i == 2) almost_full = 1'b0;
      if (retrig && i == 3) almost_full = 1'b1;
      if (i >= words - 1) almost_empty = 1'b1;
      if (rd_valid) validSeen++;
      if (burst_done) begin
        doneSeen++;
        checkOutput("burstDoneCycle", 32'(i), 32'(words + 1));
      end
    end
    checkOutput("rdValidCount", 32'(validSeen), 32'(words));
    checkOutput("burstDoneCount", 32'(doneSeen), 32'd1);
    checkOutput("burstLen", 32'(burst_len), 32'(words));
    checkOutput("rdEnLowAfter", 32'(fifo_rd_en), 32'd0);
    checkOutput("fifoDrained", 32'(fifoQ.size()), 32'd0);
    checkOutput("rdDataHold", 32'(rd_data), 32'(lastWord));
    if (retrig) begin
      sawRdEn = 0;
      for (int j = 0; j < DLY + 8; j++) begin
        @(negedge sys_clk);
        if (fifo_rd_en) sawRdEn = 1;
      end
      checkOutput("noSecondBurst", 32'(sawRdEn), 32'd0);
    end
    almost_full  = 1'b0;
    almost_empty = 1'b0;
    modelNext    = '0;
    fifoQ.delete();
    repeat (3) @(posedge sys_clk);
  endtask

  initial begin : stimulus
    int c;
    vecs[0] = '{words: 12,  corruptIdx: -1, corruptVal: 8'h00, aeEarly: 1'b0, retrig: 1'b0, expErr: 1'b0};
    vecs[1] = '{words: 258, corruptIdx: -1, corruptVal: 8'h00, aeEarly: 1'b0, retrig: 1'b0, expErr: 1'b0};
    vecs[2] = '{words: 8,   corruptIdx: -1, corruptVal: 8'h00, aeEarly: 1'b0, retrig: 1'b1, expErr: 1'b0};
    vecs[3] = '{words: 1,   corruptIdx: -1, corruptVal: 8'h00, aeEarly: 1'b1, retrig: 1'b0, expErr: 1'b0};
    vecs[4] = '{words: 10,  corruptIdx: 5,  corruptVal: 8'h07, aeEarly: 1'b0, retrig: 1'b0, expErr: 1'b1};
    vecs[5] = '{words: 9,   corruptIdx: -1, corruptVal: 8'h00, aeEarly: 1'b0, retrig: 1'b0, expErr: 1'b1};

    // Reset state
    repeat (3) @(negedge sys_clk);
    checkOutput("rstRdEn", 32'(fifo_rd_en), 32'd0);
    checkOutput("rstRdValid", 32'(rd_valid), 32'd0);
    checkOutput("rstRdData", 32'(rd_data), 32'd0);
    checkOutput("rstBurstDone", 32'(burst_done), 32'd0);
    checkOutput("rstErrFlag", 32'(err_flag), 32'd0);
    checkOutput("rstBurstLen", 32'(burst_len), 32'd0);
    sys_rst_n = 1'b1;
    monOn     = 1'b1;
    repeat (3) @(posedge sys_clk);

    // Directed bursts from the table
    for (int t = 0; t < 6; t++) begin
      applyStimulus(vecs[t].words, vecs[t].corruptIdx, vecs[t].corruptVal, vecs[t].aeEarly, vecs[t].retrig);
      checkOutput("errAfterBurst", 32'(err_flag), 32'(vecs[t].expErr));
    end

    // Reset in the middle of a read burst
    for (int i = 0; i < 20; i++) fifoQ.push_back(DW'(i));
    @(posedge sys_clk);
    #1;
    almost_full = 1'b1;
    for (c = 1; c <= LATENCY + 20; c++) begin
      @(posedge sys_clk);
      @(negedge sys_clk);
      if (c == 2) almost_full = 1'b0;
      if (fifo_rd_en) break;
    end
    checkOutput("rstTestReading", 32'(fifo_rd_en), 32'd1);
    repeat (3) @(posedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    modelErr  = 1'b0;
    modelNext = '0;
    fifoQ.delete();
    poppedQ.delete();
    #1;
    checkOutput("rstRdEnAsync", 32'(fifo_rd_en), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge sys_clk);
      checkOutput("rstOutputsZero",
                  32'({fifo_rd_en, rd_valid, burst_done, err_flag, rd_data, burst_len}), 32'd0);
    end
    sys_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge sys_clk);
      checkOutput("noDoneAfterAbort", 32'({burst_done, fifo_rd_en}), 32'd0);
    end
    applyStimulus(6, -1, 8'h00, 1'b0, 1'b0);
    checkOutput("errAfterRstBurst", 32'(err_flag), 32'd0);

    // Randomised bursts against the stream model
    for (int r = 0; r < 6; r++) begin
      int         words;
      int         cidx;
      logic [7:0] cval;
      words = int'($urandom_range(12, 1));
      cidx  = ($urandom_range(2, 0) == 0) ? int'($urandom_range(words - 1, 0)) : -1;
      cval  = 8'($urandom);
      applyStimulus(words, cidx, cval, 1'b0, 1'b0);
      checkOutput("errRandomBurst", 32'(err_flag), 32'(modelErr));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fifo_read.md
FIFO_READ -- requirements
Module: fifo_read

Interface
REQ-001 Parameter DATA_W, default 8, SHALL set the data width of the FIFO read port and of the checker.
REQ-002 Parameter DELAY_CYCLES, default 10, SHALL set the number of settle cycles between the trigger and the first read.
REQ-003 Port sys_clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-004 Port sys_rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port almost_full, input, 1 bit: FIFO almost-full flag; its rising edge triggers a read burst.
REQ-006 Port almost_empty, input, 1 bit: FIFO almost-empty flag; terminates a read burst.
REQ-007 Port fifo_rdata, input, DATA_W bits: FIFO read data, valid 1 cycle after fifo_rd_en is sampled high.
REQ-008 Port fifo_rd_en, output, 1 bit: FIFO read enable, registered.
REQ-009 Port rd_valid, output, 1 bit: high for the cycle in which rd_data holds a captured word.
REQ-010 Port rd_data, output, DATA_W bits: captured FIFO word.
REQ-011 Port burst_done, output, 1 bit: one-cycle pulse at the end of each burst.
REQ-012 Port err_flag, output, 1 bit: sticky data-sequence error.
REQ-013 Port burst_len, output, 16 bits: number of words captured in the last completed burst.

Function
REQ-014 almost_full SHALL pass through two flops (af_t0, af_t1); trigger = af_t0 & ~af_t1. Trigger latency is 2 cycles from the input edge.
REQ-015 The FSM SHALL have 4 states: IDLE, DELAY, READ, DRAIN. Any illegal encoding SHALL return to IDLE.
REQ-016 IDLE: on trigger, go to DELAY with delay_cnt = 0. Otherwise stay in IDLE.
REQ-017 DELAY: increment delay_cnt each cycle. When delay_cnt == DELAY_CYCLES, go to READ, set fifo_rd_en = 1 and clear delay_cnt.
REQ-018 READ: if almost_empty is sampled high, clear fifo_rd_en and go to DRAIN. Otherwise hold fifo_rd_en = 1.
REQ-019 DRAIN: stay exactly 1 cycle, so the last word's rd_valid occurs. Then pulse burst_done, load burst_len from the word counter, clear the word counter and expected value, and go to IDLE.
REQ-020 rd_valid SHALL equal fifo_rd_en delayed by 1 cycle. rd_data SHALL capture fifo_rdata in that same cycle. rd_data holds its value while rd_valid is low.
REQ-021 Checker: expected starts at 0. On each rd_valid, compare rd_data to expected; on mismatch set err_flag. Then set expected = rd_data + 1, wrapping modulo 2^DATA_W, so the checker resynchronises after an error.
REQ-022 err_flag SHALL clear only on reset.
REQ-023 Word counter: incremented on each rd_valid; saturates at 16'hFFFF.
REQ-024 A trigger occurring while in DELAY, READ or DRAIN SHALL be ignored and SHALL NOT be queued.
REQ-025 If almost_empty is high on the first READ cycle, the burst SHALL still read exactly 1 word.
REQ-026 If almost_full and almost_empty are both high in READ, almost_empty SHALL win and the burst ends.
REQ-027 The checker SHALL accept 8'hFF followed by 8'h00 as in sequence.

Reset
REQ-028 While sys_rst_n is low, all outputs SHALL be held at 0: fifo_rd_en, rd_valid, rd_data, burst_done, err_flag, burst_len.
REQ-029 While sys_rst_n is low, the FSM SHALL be in IDLE, and delay_cnt, the word counter, expected, af_t0 and af_t1 SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL drop fifo_rd_en asynchronously. No burst_done pulse SHALL be produced for the aborted burst.

Structure
REQ-031 The FSM state encoding, DELAY_CYCLES default and DATA_W default SHALL live in a shared package (fifo_pkg), also used by fifo_write.
REQ-032 The checker (REQ-021..023) SHALL be a sub-module named fifo_seq_check, with inputs rd_valid, rd_data and a clear signal.

Verification
REQ-033 FIFO depth 256. Writer fills 0..N; almost_full rises. Required: fifo_rd_en rises 2+DELAY_CYCLES+1 cycles after the edge; data 0,1,2... is read in order; err_flag = 0; burst_done pulses once.
REQ-034 Inject a corrupted word (0x05 replaced by 0x07) at word 5. Required: err_flag = 1 from the cycle after that word's rd_valid; err_flag stays 1 through the following bursts; no error is reported at 0x08.
REQ-035 Pulse almost_full again during DELAY and during READ. Required: no second burst and no change in DELAY timing.
REQ-036 almost_empty held high when READ is entered. Required: exactly 1 rd_valid; burst_len = 1.
REQ-037 Assert sys_rst_n low for 3 cycles mid-READ. Required: fifo_rd_en = 0 immediately; all outputs 0; no burst_done; the next almost_full edge starts a normal burst.
REQ-038 Sequence crossing 0xFE, 0xFF, 0x00, 0x01. Required: err_flag stays 0; burst_len equals the number of words read.
